// File: rtl/rf_bypass_8x16_pkg.sv
// Shared definitions for the 8x16 register file.
// Also used by decode and the hazard unit for register numbers.
package rf_bypass_8x16_pkg;

    localparam int unsigned RF_NUM_REGS = 8;
    localparam int unsigned RF_SEL_W    = 3;
    localparam int unsigned RF_DATA_W   = 16;

    typedef logic [RF_SEL_W-1:0] rf_sel_t;

endpackage

// File: rtl/rf_bypass_8x16_mux8_1.sv
// One-bit 8:1 multiplexer; one instance per data bit per read port.
//   i_d    : bit i of R0..R7
//   i_sel  : register number
//   o_y_c  : selected bit (combinational)
module mux8_1
    import rf_bypass_8x16_pkg::*;
(
    input  logic [RF_NUM_REGS-1:0] i_d,
    input  rf_sel_t                i_sel,
    output logic                   o_y_c
);

    assign o_y_c = i_d[i_sel];

endmodule

// File: rtl/rf_bypass_8x16_rf_reg.sv
// Single DATA_W-bit storage register with synchronous active-high reset
// and write enable.
//   clk, rst   : clock, synchronous active-high reset
//   i_we       : write enable
//   i_d        : write data
//   o_q        : stored value
module rf_reg #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // Reset has priority over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/rf_bypass_8x16.sv
// Eight-entry, two-read/one-write register file for the decode stage.
// Optional write-to-read bypass enabled by defining RF_BYPASS_EN.
//   clk, rst              : clock, synchronous active-high reset
//   read1RegSel/read2RegSel : read port register numbers
//   writeRegSel, writeData, writeEn : write port
//   read1Data/read2Data   : combinational read operands
//   err                   : registered flag for X/Z on the write controls
module rf_bypass_8x16
    import rf_bypass_8x16_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  rf_sel_t           read1RegSel,
    input  rf_sel_t           read2RegSel,
    input  rf_sel_t           writeRegSel,
    input  logic [DATA_W-1:0] writeData,
    input  logic              writeEn,
    output logic [DATA_W-1:0] read1Data,
    output logic [DATA_W-1:0] read2Data,
    output logic              err
);

    logic [RF_NUM_REGS-1:0] w_we;
    logic [DATA_W-1:0]      w_q [RF_NUM_REGS];
    logic [DATA_W-1:0]      w_rd1;
    logic [DATA_W-1:0]      w_rd2;
    logic                   r_err;

    // 3->8 one-hot write decode, gated by the write strobe.
    assign w_we = writeEn ? (RF_NUM_REGS'(1) << writeRegSel) : '0;

    for (genvar k = 0; k < RF_NUM_REGS; k++) begin : g_reg
        rf_reg #(.DATA_W(DATA_W)) u_reg (
            .clk  (clk),
            .rst  (rst),
            .i_we (w_we[k]),
            .i_d  (writeData),
            .o_q  (w_q[k])
        );
    end

    // Bit-sliced read muxes: column b gathers bit b of every register.
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        logic [RF_NUM_REGS-1:0] w_col;
        for (genvar k = 0; k < RF_NUM_REGS; k++) begin : g_col
            assign w_col[k] = w_q[k][b];
        end
        mux8_1 u_mux_rd1 (.i_d(w_col), .i_sel(read1RegSel), .o_y_c(w_rd1[b]));
        mux8_1 u_mux_rd2 (.i_d(w_col), .i_sel(read2RegSel), .o_y_c(w_rd2[b]));
    end

`ifdef RF_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    // Forward the pending write; reset suppresses it since the write is dropped.
    assign w_byp1 = writeEn && !rst && (read1RegSel == writeRegSel);
    assign w_byp2 = writeEn && !rst && (read2RegSel == writeRegSel);

    assign read1Data = w_byp1 ? writeData : w_rd1;
    assign read2Data = w_byp2 ? writeData : w_rd2;
`else
    assign read1Data = w_rd1;
    assign read2Data = w_rd2;
`endif

    // Simulation aid: flags unknown write controls; constant 0 in hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= $isunknown(writeEn) || ((writeEn === 1'b1) && $isunknown(writeRegSel));
        end
    end

    assign err = r_err;

endmodule
